// File: rtl/pmem_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache and D-cache, one line at a time.
// Build option: define ARB_RR_EN for round-robin on simultaneous requests (default: D over I).
module pmem_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy, StCooldown} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              last_d_q, last_d_d;  // 1: most recent grant went to the D-cache
  logic              i_req, d_req, grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_RR_EN
  assign grant_d = d_req & (~i_req | ~last_d_q);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      last_d_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      last_d_q <= last_d_d;
    end
  end

  // Grants happen only from StIdle, so a cache still holding its request during
  // StCooldown can never win a second, spurious transaction.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    last_d_d = last_d_q;
    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          last_d_d = grant_d;
          if (grant_d) begin
            state_d = StDBusy;
            addr_d  = d_pmem_address;
            wdata_d = d_pmem_wdata;
            write_d = d_pmem_write;
          end else begin
            state_d = StIBusy;
            addr_d  = i_pmem_address;
            wdata_d = '0;
            write_d = 1'b0;
          end
        end
      end
      StIBusy, StDBusy: begin
        if (mem_resp) state_d = StCooldown;
      end
      StCooldown: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = addr_q;
    mem_wdata    = wdata_q;
    i_pmem_resp  = 1'b0;
    i_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    unique case (state_q)
      StIBusy: begin
        mem_read  = ~write_q;
        mem_write = write_q;
        if (mem_resp) begin
          i_pmem_resp  = 1'b1;
          i_pmem_rdata = mem_rdata;
        end
      end
      StDBusy: begin
        mem_read  = ~write_q;
        mem_write = write_q;
        if (mem_resp) begin
          d_pmem_resp  = 1'b1;
          d_pmem_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: directed scenarios, then randomized cache/adaptor traffic
// checked against a transaction-level reference model.
module tb_pmem_arbiter;

  logic         clk, rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read, d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  pmem_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         who;   // 1: D-cache
    logic [255:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks, errors;
  bit   sim_done;
  int   done_cnt;

  // Reference model: which transaction the shared port should be carrying.
  bit           m_busy, m_cool, m_who, m_last, m_wr;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // Adaptor completes the line; expected response goes to the scoreboard at the same time.
  task automatic drive_resp(input logic who, input logic [255:0] data);
    exp_t e;
    e.who     = who;
    e.data    = data;
    exp_q.push_back(e);
    mem_resp  = 1'b1;
    mem_rdata = data;
    tick();
    mem_resp  = 1'b0;
    mem_rdata = rand256();
  endtask

  task automatic monitor_loop();
    exp_t e;
    logic who;
    logic d_req;
    while (!sim_done) begin
      @(negedge clk);
      check("mem_read", 256'(mem_read), 256'(m_busy && !m_wr));
      check("mem_write", 256'(mem_write), 256'(m_busy && m_wr));
      if (m_busy) begin
        check("mem_address", 256'(mem_address), 256'(m_addr));
        check("mem_wdata", mem_wdata, m_wdata);
      end
      if (i_pmem_resp && d_pmem_resp) begin
        errors++;
        $display("FAIL both_resp: got i=1 d=1 required at most one");
      end
      if (i_pmem_resp || d_pmem_resp) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got i=%0b d=%0b required none", i_pmem_resp,
                   d_pmem_resp);
        end else begin
          e = exp_q.pop_front();
          check("resp_who", 256'(d_pmem_resp), 256'(e.who));
          check("resp_rdata", d_pmem_resp ? d_pmem_rdata : i_pmem_rdata, e.data);
        end
      end
      if (!i_pmem_resp) check("i_rdata_zero", i_pmem_rdata, '0);
      if (!d_pmem_resp) check("d_rdata_zero", d_pmem_rdata, '0);

      d_req = d_pmem_read || d_pmem_write;
      if (rst) begin
        m_busy = 0; m_cool = 0; m_last = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
      end else if (m_busy) begin
        if (mem_resp) begin
          m_busy = 0;
          m_cool = 1;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (i_pmem_read || d_req) begin
`ifdef ARB_RR_EN
        who = (i_pmem_read && d_req) ? !m_last : d_req;
`else
        who = d_req;
`endif
        m_busy  = 1;
        m_who   = who;
        m_last  = who;
        m_wr    = who ? d_pmem_write : 1'b0;
        m_addr  = who ? d_pmem_address : i_pmem_address;
        m_wdata = who ? d_pmem_wdata : '0;
      end
    end
  endtask

  task automatic wait_resp(input logic who);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(who ? d_pmem_resp : i_pmem_resp) && t < 400);
    if (!(who ? d_pmem_resp : i_pmem_resp)) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no resp for %s after %0d cycles required resp",
               who ? "D" : "I", t);
    end
  endtask

  // Cache controller behaviour: hold until resp, keep holding one more cycle, then drop.
  task automatic run_req(input logic who, input int n);
    logic [1:0] op;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      if (who) begin
        op             = 2'($urandom_range(0, 2));
        d_pmem_address = $urandom() & 32'hffff_ffe0;
        d_pmem_wdata   = rand256();
        d_pmem_read    = (op != 2'd1);
        d_pmem_write   = (op != 2'd0);
      end else begin
        i_pmem_address = $urandom() & 32'hffff_ffe0;
        i_pmem_read    = 1'b1;
      end
      wait_resp(who);
      tick();
      tick();
      if (who) begin
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
      end else begin
        i_pmem_read = 1'b0;
      end
    end
    done_cnt++;
  endtask

  task automatic run_adaptor();
    while (done_cnt < 2) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        tick();
        drive_resp(m_who, rand256());
      end
    end
  endtask

  task automatic main_seq();
    logic [255:0] pat;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", 256'({mem_read, mem_write, i_pmem_resp, d_pmem_resp, mem_address}), '0);
    check("reset_data", mem_wdata | i_pmem_rdata | d_pmem_rdata, '0);

    // Lone I read, response five cycles after the command appears
    tick();
    i_pmem_read = 1'b1; i_pmem_address = 32'h40;
    tick();
    @(negedge clk);
    check("t1_mem_read", 256'(mem_read), 256'(1));
    check("t1_mem_address", 256'(mem_address), 256'(32'h40));
    repeat (4) tick();
    drive_resp(1'b0, rand256());
    @(negedge clk);
    check("t1_cooldown_no_cmd", 256'({mem_read, mem_write}), '0);
    tick();
    i_pmem_read = 1'b0;
    repeat (2) tick();

    // Simultaneous I and D reads: D first, then I straight after the cooldown
    i_pmem_read = 1'b1; i_pmem_address = 32'h100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h200;
    tick();
    @(negedge clk);
    check("t2_first_addr", 256'(mem_address), 256'(32'h200));
    tick();
    drive_resp(1'b1, rand256());
    tick();
    d_pmem_read = 1'b0;
    tick();
    @(negedge clk);
    check("t2_second_addr", 256'(mem_address), 256'(32'h100));
    tick();
    drive_resp(1'b0, rand256());
    tick();
    i_pmem_read = 1'b0;
    repeat (2) tick();

    // D writeback; the cache scribbles over its inputs mid-transaction
    pat = {32{8'hA5}};
    d_pmem_write = 1'b1; d_pmem_address = 32'h80; d_pmem_wdata = pat;
    tick();
    d_pmem_wdata = rand256(); d_pmem_address = 32'hdead_bee0;
    tick();
    @(negedge clk);
    check("t3_mem_write", 256'(mem_write), 256'(1));
    check("t3_wdata_latched", mem_wdata, pat);
    check("t3_addr_latched", 256'(mem_address), 256'(32'h80));
    check("t3_no_i_resp", 256'(i_pmem_resp), '0);
    tick();
    drive_resp(1'b1, rand256());
    tick();
    d_pmem_write = 1'b0;
    repeat (2) tick();

    // D arrives while I is busy: waits for I, cooldown, then IDLE
    i_pmem_read = 1'b1; i_pmem_address = 32'h300;
    tick();
    d_pmem_read = 1'b1; d_pmem_address = 32'h400;
    repeat (2) tick();
    drive_resp(1'b0, rand256());
    tick();
    i_pmem_read = 1'b0;
    tick();
    @(negedge clk);
    check("t4_d_after_wait", 256'({mem_read, mem_write, mem_address}), 256'({2'b10, 32'h400}));
    tick();
    drive_resp(1'b1, rand256());
    tick();
    d_pmem_read = 1'b0;
    repeat (2) tick();

    // Reset while D is busy abandons the transaction
    d_pmem_read = 1'b1; d_pmem_address = 32'h500;
    tick();
    tick();
    rst = 1'b1; d_pmem_read = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_ctrl", 256'({mem_read, mem_write, i_pmem_resp, d_pmem_resp, mem_address}), '0);
    check("t5_rst_data", mem_wdata | i_pmem_rdata | d_pmem_rdata, '0);
    tick();
    i_pmem_read = 1'b1; i_pmem_address = 32'h600;
    repeat (2) tick();
    drive_resp(1'b0, rand256());
    tick();
    i_pmem_read = 1'b0;
    repeat (2) tick();

    // Read and write both set behaves as a write
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h700; d_pmem_wdata = rand256();
    tick();
    @(negedge clk);
    check("t6_rw_is_write", 256'({mem_read, mem_write}), 256'(2'b01));
    tick();
    drive_resp(1'b1, rand256());
    tick();
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    repeat (2) tick();

    // Stray mem_resp with nothing outstanding is not forwarded
    mem_resp = 1'b1; mem_rdata = rand256();
    @(negedge clk);
    check("t7_stray_resp", 256'({i_pmem_resp, d_pmem_resp}), '0);
    tick();
    mem_resp = 1'b0;
    repeat (2) tick();

    fork
      run_req(1'b0, 40);
      run_req(1'b1, 40);
      run_adaptor();
    join
    repeat (4) tick();
    check("scoreboard_drained", 256'(exp_q.size()), '0);
  endtask

  initial begin
    checks = 0; errors = 0; sim_done = 0; done_cnt = 0;
    m_busy = 0; m_cool = 0; m_who = 0; m_last = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    fork
      monitor_loop();
      begin
        main_seq();
        sim_done = 1'b1;
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
Shares the single physical-memory port (cacheline adaptor side) between the pipelined I-cache and the D-cache. Each cache sees a private pmem interface. The arbiter grants one whole line transaction at a time, latches the command, forwards the response, then inserts a one-cycle cooldown. Sits between both cache controllers and the cacheline adaptor in the mp4 top level.

Parameters:
LINE_W, 256, cache line width in bits
ADDR_W, 32, physical address width

Ports:
clk  in  1  clock
rst  in  1  reset
i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp
i_pmem_address  in  ADDR_W  I-cache line address
i_pmem_rdata  out  LINE_W  line data to I-cache
i_pmem_resp  out  1  I-cache transaction complete
d_pmem_read  in  1  D-cache line read request, held until d_pmem_resp
d_pmem_write  in  1  D-cache writeback request, held until d_pmem_resp
d_pmem_address  in  ADDR_W  D-cache line address
d_pmem_wdata  in  LINE_W  D-cache writeback data
d_pmem_rdata  out  LINE_W  line data to D-cache
d_pmem_resp  out  1  D-cache transaction complete
mem_read  out  1  read command to adaptor
mem_write  out  1  write command to adaptor
mem_address  out  ADDR_W  latched transaction address
mem_wdata  out  LINE_W  latched writeback data
mem_rdata  in  LINE_W  line from adaptor
mem_resp  in  1  adaptor transaction complete

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- State after reset: IDLE. On reset, all outputs are 0, including the rdata buses. The arbiter clears its latched address, wdata and op registers, and sets last_grant to I.
- FSM states: IDLE, I_BUSY, D_BUSY, COOLDOWN.
- IDLE: evaluate requests each cycle, excluding any requester masked by cooldown. On a grant:
  - latch address, wdata and op (read/write) from the winner;
  - move to I_BUSY or D_BUSY.
  - The mem_* command asserts in the cycle after the request was sampled, so grant latency is 1 cycle.
- Arbitration priority:
  - D-cache wins when both request in the same cycle (default build).
  - D request with both d_pmem_read and d_pmem_write set is treated as a write.
- I_BUSY / D_BUSY:
  - mem_read or mem_write held at 1 from the latched op.
  - mem_address and mem_wdata driven from the latch.
  - Changes on the requester's inputs mid-transaction are ignored.
- Response path, on the mem_resp cycle:
  - the granted requester's *_pmem_resp is 1 and its *_pmem_rdata = mem_rdata, both combinational in the same cycle;
  - the other requester's resp is 0 and its rdata is held at 0;
  - mem_read and mem_write drop in the next cycle; next state is COOLDOWN.
- COOLDOWN (exactly 1 cycle):
  - no mem command is issued;
  - the just-served requester's request is masked, because a cache controller still holds its request for one cycle after resp while it updates tag/valid;
  - the other requester's request is not masked but is only sampled; it is granted from IDLE, never from COOLDOWN.
  - Next state is always IDLE.
- mem_resp outside I_BUSY/D_BUSY is ignored and no response is forwarded.
- Reset mid-transaction: the arbiter returns to IDLE next cycle with all commands deasserted and the outstanding transaction abandoned. The adaptor shares rst.
- Requests are level-held. Dropping a request before resp is illegal; the transaction still completes and the response is delivered anyway.

Optional Feature:
Macro ARB_RR_EN.
- Defined: when both requests are present in IDLE, the arbiter grants the requester that is not last_grant (round-robin). last_grant updates on every grant.
- Undefined: fixed D-over-I priority; last_grant is still tracked but unused.

Test Plan:
- Lone I read, addr 0x00000040, adaptor resp after 5 cycles -> mem_read=1 with mem_address=0x40 from cycle 1; i_pmem_resp=1 with rdata=mem_rdata on the resp cycle; COOLDOWN next cycle; no re-grant while i_pmem_read stays 1 during cooldown.
- I read 0x100 and D read 0x200 in the same cycle -> D served first. Default build: I granted immediately after the cooldown. With ARB_RR_EN and last_grant=D: I served first.
- D writeback addr 0x80, wdata 0xA5..A5 -> mem_write=1 with latched wdata. Changing d_pmem_wdata mid-transaction does not alter mem_wdata. d_pmem_resp on the resp cycle; i_pmem_resp stays 0 throughout.
- D request arrives while I_BUSY -> D waits. Granted via IDLE after COOLDOWN, with no cycle in which mem_read and mem_write are both 1.
- rst asserted during D_BUSY -> next cycle: IDLE, all outputs 0. A fresh I request afterwards completes normally.
- Both d_pmem_read and d_pmem_write set -> treated as a write: mem_write=1, mem_read=0.
